// File: rtl/decode_useq.sv
// Sequential decode stage: one uop per DP/memory/branch instruction, one uop per listed
// register for LDM/STM. Optional feature macro: DECODE_WB_UOP_EN (base-update uop on W=1).
module decode_useq #(
  parameter int NREGS     = 16,
  parameter int ALUCTRL_W = 5,
  localparam int OFF_W    = $clog2(NREGS) + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [NREGS-1:0]     RegList,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 RegW,
  output logic                 MemW,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 Branch,
  output logic                 PCS,
  output logic                 NoWrite,
  output logic                 IgRn,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           FlagW,
  output logic [3:0]           UopRd,
  output logic [OFF_W-1:0]     UopOffset,
  output logic                 UopLast,
  output logic                 Undef
);

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_ORR = 5'b00011;
  localparam logic [4:0] ALU_EOR = 5'b00110;
  localparam logic [4:0] ALU_RSB = 5'b01000;
  localparam logic [4:0] ALU_BIC = 5'b10010;

  localparam logic [NREGS-1:0] ONE_L    = NREGS'(1);
  localparam logic [OFF_W-1:0] OFF_STEP = OFF_W'(4);

  typedef enum logic {IDLE, EMIT} state_t;

  typedef struct packed {
    logic             reg_w;
    logic             mem_w;
    logic             mem_to_reg;
    logic             alu_src;
    logic             branch;
    logic             pcs;
    logic             no_write;
    logic             ig_rn;
    logic [1:0]       imm_src;
    logic [1:0]       reg_src;
    logic [4:0]       alu;
    logic [1:0]       flag_w;
    logic [3:0]       rd;
    logic [OFF_W-1:0] off;
    logic             last;
    logic             undef;
  } uop_t;

  state_t           state_r, state_nx_s;
  uop_t             uop_r, dec_s, nxt_s;
  logic             out_valid_r;
  logic [NREGS-1:0] rem_r, rem_nx_s;
  logic             wb_pend_r;
  logic             l_r;
  logic [3:0]       base_r;
  logic             accept_s, handoff_s, multi_s, blk_s, wb_en_s, last_hand_s;

  function automatic logic [3:0] low_idx(input logic [NREGS-1:0] l);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (l[i]) r = 4'(i);
      else      r = r;
    end
    return r;
  endfunction

  function automatic uop_t with_pcs(input uop_t u);
    uop_t r;
    r = u;
    r.pcs = ((u.rd == 4'd15) & u.reg_w) | u.branch;
    return r;
  endfunction

  function automatic uop_t blk_uop(input logic [3:0] idx, input logic ld,
                                   input logic [OFF_W-1:0] off, input logic last);
    uop_t r;
    r = '0;
    r.mem_w      = ~ld;
    r.reg_w      = ld;
    r.mem_to_reg = ld;
    r.alu_src    = 1'b1;
    r.alu        = ALU_ADD;
    r.imm_src    = 2'b10;
    r.rd         = idx;
    r.off        = off;
    r.last       = last;
    return with_pcs(r);
  endfunction

`ifdef DECODE_WB_UOP_EN
  assign wb_en_s = Funct[1];
`else
  assign wb_en_s = 1'b0;
`endif

  assign blk_s     = (Op == 2'b10) & ~Funct[5];
  assign multi_s   = blk_s & ((|(RegList & (RegList - ONE_L))) | wb_en_s);
  assign in_ready  = (state_r == IDLE) & (~out_valid_r | out_ready) & ~flush;
  assign accept_s  = in_valid & in_ready;
  assign handoff_s = out_valid_r & out_ready;

  // Decode of the incoming instruction into its first (often only) uop
  always_comb begin
    dec_s         = '0;
    dec_s.rd      = Rd;
    dec_s.imm_src = Op;
    dec_s.last    = 1'b1;
    case (Op)
      2'b00: begin
        dec_s.alu_src = Funct[5];
        case (Funct[4:1])
          4'b0000: dec_s.alu = ALU_AND;
          4'b0001: dec_s.alu = ALU_EOR;
          4'b0010: dec_s.alu = ALU_SUB;
          4'b0011: dec_s.alu = ALU_RSB;
          4'b0100: dec_s.alu = ALU_ADD;
          4'b1100: dec_s.alu = ALU_ORR;
          4'b1110: dec_s.alu = ALU_BIC;
          4'b1101: begin dec_s.alu = ALU_ADD; dec_s.ig_rn = 1'b1;    end
          4'b1000: begin dec_s.alu = ALU_AND; dec_s.no_write = 1'b1; end
          4'b1001: begin dec_s.alu = ALU_EOR; dec_s.no_write = 1'b1; end
          4'b1010: begin dec_s.alu = ALU_SUB; dec_s.no_write = 1'b1; end
          4'b1011: begin dec_s.alu = ALU_ADD; dec_s.no_write = 1'b1; end
          default: dec_s.undef = 1'b1;
        endcase
        if (dec_s.undef) begin
          dec_s.flag_w = 2'b00;
          dec_s.reg_w  = 1'b0;
        end else begin
          dec_s.flag_w = {Funct[0], Funct[0] & ~dec_s.alu[1]};
          dec_s.reg_w  = ~dec_s.no_write;
        end
      end
      2'b01: begin
        dec_s.reg_w      = Funct[0];
        dec_s.mem_to_reg = Funct[0];
        dec_s.mem_w      = ~Funct[0];
        dec_s.alu_src    = ~Funct[5];
        dec_s.alu        = Funct[3] ? ALU_ADD : ALU_SUB;
        dec_s.reg_src    = {~Funct[0], 1'b0};
      end
      2'b10: begin
        if (Funct[5]) begin
          dec_s.branch  = 1'b1;
          dec_s.reg_src = 2'b01;
          dec_s.alu_src = 1'b1;
          dec_s.alu     = ALU_ADD;
        end else if (|RegList) begin
          dec_s = blk_uop(low_idx(RegList), Funct[0], {OFF_W{1'b0}}, ~multi_s);
        end else begin
          // empty list: a single uop with no write enables so the instruction still retires
          dec_s.alu_src = 1'b1;
          dec_s.last    = ~wb_en_s;
        end
      end
      default: dec_s.undef = 1'b1;
    endcase
    dec_s = with_pcs(dec_s);
  end

  // Next uop of an in-flight block transfer, taken on each handoff in EMIT
  always_comb begin
    rem_nx_s = rem_r & (rem_r - ONE_L);
    nxt_s    = '0;
    if (|rem_nx_s) begin
      nxt_s = blk_uop(low_idx(rem_nx_s), l_r, uop_r.off + OFF_STEP,
                      ~(|(rem_nx_s & (rem_nx_s - ONE_L))) & ~wb_pend_r);
    end else if (wb_pend_r) begin
      nxt_s.rd      = base_r;
      nxt_s.reg_w   = 1'b1;
      nxt_s.alu_src = 1'b1;
      nxt_s.alu     = ALU_ADD;
      nxt_s.imm_src = 2'b10;
      nxt_s.last    = 1'b1;
      nxt_s.off     = (|rem_r) ? (uop_r.off + OFF_STEP) : {OFF_W{1'b0}};
      nxt_s         = with_pcs(nxt_s);
    end else begin
      nxt_s = '0;
    end
  end

  assign last_hand_s = handoff_s & ~(|rem_nx_s) & ~wb_pend_r;

  // FSM next state; EMIT is held until the final uop of a block is handed off
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (flush)                    state_nx_s = IDLE;
        else if (accept_s & multi_s)  state_nx_s = EMIT;
        else                          state_nx_s = IDLE;
      end
      EMIT: begin
        if (flush)             state_nx_s = IDLE;
        else if (last_hand_s)  state_nx_s = IDLE;
        else                   state_nx_s = EMIT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Uop output registers and block-expansion bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uop_r       <= '0;
      out_valid_r <= 1'b0;
      rem_r       <= '0;
      wb_pend_r   <= 1'b0;
      l_r         <= 1'b0;
      base_r      <= 4'd0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
      rem_r       <= '0;
      wb_pend_r   <= 1'b0;
    end else if (accept_s) begin
      uop_r       <= dec_s;
      out_valid_r <= 1'b1;
      rem_r       <= blk_s ? RegList : '0;
      wb_pend_r   <= blk_s & wb_en_s;
      l_r         <= Funct[0];
      base_r      <= Rd;
    end else if (handoff_s & (state_r == EMIT)) begin
      if ((|rem_nx_s) | wb_pend_r) begin
        uop_r     <= nxt_s;
        rem_r     <= rem_nx_s;
        wb_pend_r <= wb_pend_r & (|rem_nx_s);
      end else begin
        out_valid_r <= 1'b0;
        rem_r       <= '0;
      end
    end else if (handoff_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign RegW       = uop_r.reg_w;
  assign MemW       = uop_r.mem_w;
  assign MemtoReg   = uop_r.mem_to_reg;
  assign ALUSrc     = uop_r.alu_src;
  assign Branch     = uop_r.branch;
  assign PCS        = uop_r.pcs;
  assign NoWrite    = uop_r.no_write;
  assign IgRn       = uop_r.ig_rn;
  assign ImmSrc     = uop_r.imm_src;
  assign RegSrc     = uop_r.reg_src;
  assign ALUControl = ALUCTRL_W'(uop_r.alu);
  assign FlagW      = uop_r.flag_w;
  assign UopRd      = uop_r.rd;
  assign UopOffset  = uop_r.off;
  assign UopLast    = uop_r.last;
  assign Undef      = uop_r.undef;

endmodule

// File: tb/tb_decode_useq.sv
// Self-checking bench for decode_useq: queue-based uop model, directed cases, random traffic.
module tb_decode_useq;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [15:0] RegList;
  logic        RegW, MemW, MemtoReg, ALUSrc, Branch, PCS, NoWrite, IgRn, UopLast, Undef;
  logic [1:0]  ImmSrc, RegSrc, FlagW;
  logic [4:0]  ALUControl;
  logic [3:0]  UopRd;
  logic [5:0]  UopOffset;

  always #5 clk = ~clk;

  decode_useq #(.NREGS(16), .ALUCTRL_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Op(Op), .Funct(Funct), .Rd(Rd), .RegList(RegList), .out_valid(out_valid),
    .out_ready(out_ready), .RegW(RegW), .MemW(MemW), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
    .Branch(Branch), .PCS(PCS), .NoWrite(NoWrite), .IgRn(IgRn), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .ALUControl(ALUControl), .FlagW(FlagW), .UopRd(UopRd),
    .UopOffset(UopOffset), .UopLast(UopLast), .Undef(Undef)
  );

  typedef struct packed {
    logic       reg_w, mem_w, mem_to_reg, alu_src, branch, pcs, no_write, ig_rn, undef, last;
    logic [1:0] imm_src, reg_src, flag_w;
    logic [4:0] alu;
    logic [3:0] rd;
    logic [5:0] off;
  } uop_t;

  uop_t q[$];
  bit   multi_inst = 1'b0;
  int   checks = 0;
  int   passes = 0;

  function automatic uop_t dut_uop();
    uop_t u;
    u = '{RegW, MemW, MemtoReg, ALUSrc, Branch, PCS, NoWrite, IgRn, Undef, UopLast,
          ImmSrc, RegSrc, FlagW, ALUControl, UopRd, UopOffset};
    return u;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Expected uop list of one instruction, straight from the decode rules
  function automatic void model_push(input logic [1:0] op, input logic [5:0] f,
                                     input logic [3:0] rd, input logic [15:0] rl);
    uop_t u;
    int   k;
    logic nw, ok;
    logic [4:0] a;
    u = '0; u.rd = rd; u.imm_src = op; u.last = 1'b1;
    if (op == 2'b00) begin
      nw = 1'b0; ok = 1'b1; a = 5'd0;
      case (f[4:1])
        4'd0:  a = 5'b00010;
        4'd1:  a = 5'b00110;
        4'd2:  a = 5'b00001;
        4'd3:  a = 5'b01000;
        4'd4:  a = 5'b00000;
        4'd12: a = 5'b00011;
        4'd14: a = 5'b10010;
        4'd13: begin a = 5'b00000; u.ig_rn = 1'b1; end
        4'd8:  begin a = 5'b00010; nw = 1'b1; end
        4'd9:  begin a = 5'b00110; nw = 1'b1; end
        4'd10: begin a = 5'b00001; nw = 1'b1; end
        4'd11: begin a = 5'b00000; nw = 1'b1; end
        default: ok = 1'b0;
      endcase
      u.alu_src = f[5];
      if (ok) begin
        u.alu = a; u.no_write = nw; u.reg_w = !nw;
        u.flag_w = {f[0], f[0] & (a[1] == 1'b0)};
      end else begin
        u.undef = 1'b1;
      end
    end else if (op == 2'b01) begin
      u.reg_w = f[0]; u.mem_to_reg = f[0]; u.mem_w = !f[0]; u.alu_src = !f[5];
      u.alu = f[3] ? 5'd0 : 5'd1; u.reg_src = {!f[0], 1'b0};
    end else if (op == 2'b10 && f[5]) begin
      u.branch = 1'b1; u.reg_src = 2'b01; u.alu_src = 1'b1;
    end else if (op == 2'b10) begin
      k = 0;
      for (int i = 0; i < 16; i++) begin
        if (rl[i]) begin
          u = '0; u.imm_src = 2'b10; u.alu_src = 1'b1; u.rd = 4'(i); u.off = 6'(4 * k);
          u.mem_w = !f[0]; u.reg_w = f[0]; u.mem_to_reg = f[0];
          u.pcs = (i == 15) && f[0];
          q.push_back(u);
          k++;
        end
      end
      if (k == 0) begin
        u = '0; u.rd = rd; u.imm_src = 2'b10; u.alu_src = 1'b1; u.last = 1'b1;
        q.push_back(u);
      end else begin
        q[q.size() - 1].last = 1'b1;
      end
      multi_inst = (k > 1);
      return;
    end else begin
      u.undef = 1'b1;
    end
    u.pcs = (rd == 4'd15 && u.reg_w) || u.branch;
    q.push_back(u);
    multi_inst = 1'b0;
  endfunction

  // One cycle: drive at the falling edge, predict, then check after the rising edge
  task automatic step(input logic iv, input logic [1:0] op, input logic [5:0] f,
                      input logic [3:0] rd, input logic [15:0] rl,
                      input logic ordy, input logic fl);
    logic exp_ir, acc, hs;
    in_valid = iv; Op = op; Funct = f; Rd = rd; RegList = rl; out_ready = ordy; flush = fl;
    #1;
    exp_ir = !fl && (q.size() == 0 || (ordy && !multi_inst));
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    acc = iv && exp_ir;
    hs  = (q.size() > 0) && ordy;
    if (fl) begin
      q.delete(); multi_inst = 1'b0;
    end else begin
      if (hs) void'(q.pop_front());
      if (q.size() == 0) multi_inst = 1'b0;
      if (acc) model_push(op, f, rd, rl);
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) check("uop", 64'(dut_uop()), 64'(q[0]));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 2'b00, 6'd0, 4'd0, 16'd0, ordy, 1'b0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [15:0] r_rl;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Op = 2'd0; Funct = 6'd0; Rd = 4'd0; RegList = 16'd0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_uop", 64'(dut_uop()), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // ADD with S set
    step(1'b1, 2'b00, 6'b001001, 4'd3, 16'd0, 1'b1, 1'b0);
    check("model_add_flagw", 64'(q[0].flag_w), 64'd3);
    check("add_alu", 64'(ALUControl), 64'd0);
    check("add_flagw", 64'(FlagW), 64'd3);
    check("add_regw", 64'(RegW), 64'd1);
    check("add_last", 64'(UopLast), 64'd1);
    idle(1'b1);

    // LDM {r0,r2,r15}; a competing ADD is refused until the last handoff
    step(1'b1, 2'b10, 6'b000001, 4'd13, 16'h8005, 1'b1, 1'b0);
    check("ldm0_rd", 64'(UopRd), 64'd0);
    check("ldm0_pcs", 64'(PCS), 64'd0);
    idle(1'b1);
    check("ldm1_rd", 64'(UopRd), 64'd2);
    check("ldm1_off", 64'(UopOffset), 64'd4);
    step(1'b1, 2'b00, 6'b001001, 4'd1, 16'd0, 1'b1, 1'b0);
    check("ldm2_rd", 64'(UopRd), 64'd15);
    check("ldm2_off", 64'(UopOffset), 64'd8);
    check("ldm2_pcs", 64'(PCS), 64'd1);
    check("ldm2_last", 64'(UopLast), 64'd1);
    step(1'b1, 2'b00, 6'b001001, 4'd1, 16'd0, 1'b1, 1'b0);
    check("ldm_done", 64'(out_valid), 64'd0);

    // STM {r0,r1} with downstream stalled on uop 0
    step(1'b1, 2'b10, 6'b000000, 4'd2, 16'h0003, 1'b1, 1'b0);
    repeat (3) begin
      idle(1'b0);
      check("stm_hold_rd", 64'(UopRd), 64'd0);
      check("stm_hold_memw", 64'(MemW), 64'd1);
    end
    idle(1'b1);
    check("stm1_rd", 64'(UopRd), 64'd1);
    check("stm1_last", 64'(UopLast), 64'd1);
    idle(1'b1);

    // flush while uop 2 of a 4-register LDM is presented
    step(1'b1, 2'b10, 6'b000001, 4'd4, 16'h000F, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("flush_pre_rd", 64'(UopRd), 64'd2);
    step(1'b0, 2'b00, 6'd0, 4'd0, 16'd0, 1'b1, 1'b1);
    check("flush_valid", 64'(out_valid), 64'd0);
    step(1'b1, 2'b00, 6'b001000, 4'd6, 16'd0, 1'b1, 1'b0);
    check("post_flush_rd", 64'(UopRd), 64'd6);
    idle(1'b1);

    // LDM with W=1: base-update uop only exists with the optional feature
    step(1'b1, 2'b10, 6'b000011, 4'd9, 16'h00F0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    check("ldmw_last_rd", 64'(UopRd), 64'd7);
    check("ldmw_last_off", 64'(UopOffset), 64'd12);
    check("ldmw_last", 64'(UopLast), 64'd1);
    idle(1'b1);
    check("ldmw_only4", 64'(out_valid), 64'd0);

    // CMP and the reserved op class
    step(1'b1, 2'b00, 6'b010101, 4'd0, 16'd0, 1'b1, 1'b0);
    check("cmp_nowrite", 64'(NoWrite), 64'd1);
    check("cmp_regw", 64'(RegW), 64'd0);
    check("cmp_flagw", 64'(FlagW), 64'd3);
    step(1'b1, 2'b11, 6'b101011, 4'd15, 16'd0, 1'b1, 1'b0);
    check("op3_undef", 64'(Undef), 64'd1);
    check("op3_enables", 64'({RegW, MemW, FlagW}), 64'd0);
    idle(1'b1);

    // asynchronous reset in the middle of an expansion
    step(1'b1, 2'b10, 6'b000001, 4'd0, 16'h00FF, 1'b1, 1'b0);
    idle(1'b1);
    in_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd1);
    q.delete(); multi_inst = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       r_rl = 16'd0;
        1:       r_rl = 16'd1 << $urandom_range(0, 15);
        2:       r_rl = 16'($urandom);
        default: r_rl = 16'($urandom) & 16'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, r_op, 6'($urandom), 4'($urandom), r_rl,
           $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
